// File: rtl/roc_fifo_event_reader.sv
// roc_fifo_event_reader: forwards header+payload events from a ROC FIFO into the EW_FIFO,
// checking tag continuity and truncating events that stall past TIMEOUT_CYC.
module roc_fifo_event_reader #(
  parameter int TIMEOUT_CYC    = 1024,
  parameter int DIGI_BITS      = 32,
  parameter int SPILL_TAG_BITS = 20
) (
  input  logic                      serdesclk,
  input  logic                      serdesclk_resetn,
  input  logic                      enable,
  input  logic                      roc_empty,
  output logic                      roc_re,
  input  logic [DIGI_BITS-1:0]      roc_data,
  input  logic                      ew_full,
  output logic                      ew_we,
  output logic [DIGI_BITS-1:0]      ew_data,
  output logic                      ew_done,
  output logic [11:0]               ew_size,
  output logic [SPILL_TAG_BITS-1:0] ew_tag,
  output logic [15:0]               evt_cnt,
  output logic                      tag_error,
  output logic                      trunc_error,
  input  logic                      clear_err
);
  localparam int SW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DONE} state_t;
  state_t                    state;
  logic [11:0]               size, iss, fwd, hdr_size, fwd_nx;
  logic [SW-1:0]             stall;
  logic [SPILL_TAG_BITS-1:0] tag, exp_tag, hdr_tag;
  logic                      rd_d, armed, start, pay_re, stalled, timeout, to_done;
  assign hdr_size = roc_data[31:20];
  assign hdr_tag  = roc_data[SPILL_TAG_BITS-1:0];
  assign start    = state == IDLE && enable && !roc_empty && !ew_full;
  assign pay_re   = state == PAYLOAD && iss < size && !roc_empty && !ew_full;
  // Reads must never be issued while held in reset, even with a live upstream FIFO.
  assign roc_re   = serdesclk_resetn && (start || pay_re);
  assign ew_we    = state == HDR || rd_d;
  assign ew_data  = ew_we ? roc_data : '0;
  assign stalled  = state == PAYLOAD && iss < size && !pay_re;
  assign timeout  = stalled && stall == SW'(TIMEOUT_CYC - 1);
  assign fwd_nx   = fwd + 12'(rd_d);
  assign to_done  = (state == HDR && hdr_size == 12'd0) ||
                    (state == PAYLOAD && (timeout || iss == size));
  always_ff @(posedge serdesclk or negedge serdesclk_resetn) begin
    if (!serdesclk_resetn) begin
      state       <= IDLE;
      size        <= '0;
      iss         <= '0;
      fwd         <= '0;
      stall       <= '0;
      tag         <= '0;
      exp_tag     <= '0;
      armed       <= 1'b0;
      rd_d        <= 1'b0;
      ew_done     <= 1'b0;
      ew_size     <= '0;
      ew_tag      <= '0;
      evt_cnt     <= '0;
      tag_error   <= 1'b0;
      trunc_error <= 1'b0;
    end else begin
      state <= state == IDLE    ? (start ? HDR : IDLE) :
               state == HDR     ? (hdr_size == 12'd0 ? DONE : PAYLOAD) :
               state == PAYLOAD ? (to_done ? DONE : PAYLOAD) : IDLE;
      ew_done <= to_done;
      if (to_done) begin
        ew_size <= state == HDR ? 12'd0 : fwd_nx;
        ew_tag  <= state == HDR ? hdr_tag : tag;
        evt_cnt <= evt_cnt + 16'd1;
      end
      rd_d <= pay_re;
      if (pay_re) begin
        iss   <= iss + 12'd1;
        stall <= '0;
      end else if (stalled) stall <= stall + 1'b1;
      if (rd_d) fwd <= fwd + 12'd1;
      tag_error   <= (state == HDR && armed && hdr_tag != exp_tag) || (tag_error && !clear_err);
      trunc_error <= timeout || (trunc_error && !clear_err);
      if (state == HDR) begin
        size    <= hdr_size;
        tag     <= hdr_tag;
        iss     <= '0;
        fwd     <= '0;
        stall   <= '0;
        exp_tag <= hdr_tag + 1'b1;
        armed   <= 1'b1;
      end
    end
  end
endmodule

// File: doc/roc_fifo_event_reader.md
# roc_fifo_event_reader

Consumes events from a SIM_ROC_FIFO (header word followed by payload words) and forwards them word by word into the downstream EW_FIFO that feeds the DDR writer. It parses the event header (`[31:20]` payload size in 32-bit words, `[19:0]` event tag), checks tag continuity, enforces EW_FIFO backpressure and terminates stalled events on a timeout. It sits between the pattern controller's ROC FIFO and the EW_FIFO/AXI DDR write path, one instance per ROC FIFO.

## Interface

- `TIMEOUT_CYC`, 1024: consecutive payload cycles without a ROC read before the event is truncated.
- `serdesclk` in 1: clock.
- `serdesclk_resetn` in 1: asynchronous, active-low reset.
- `enable` in 1: permits starting a new event. Sampled only in IDLE.
- `roc_empty` in 1: ROC FIFO empty.
- `roc_re` out 1: ROC FIFO read enable. Standard FIFO; `roc_data` is valid the cycle after `roc_re`.
- `roc_data` in `DIGI_BITS` (32): ROC FIFO read data.
- `ew_full` in 1: EW_FIFO full. The programmable threshold must assert with at least one free entry remaining.
- `ew_we` out 1: EW_FIFO write enable.
- `ew_data` out `DIGI_BITS`: EW_FIFO write data.
- `ew_done` out 1: one-cycle pulse when an event has been completely forwarded or truncated.
- `ew_size` out 12: payload words actually forwarded for the last event.
- `ew_tag` out `SPILL_TAG_BITS` (20): tag of the last event.
- `evt_cnt` out 16: events completed since reset. Wraps 0xFFFF→0.
- `tag_error` out 1: sticky; tag discontinuity seen.
- `trunc_error` out 1: sticky; event truncated by timeout.
- `clear_err` in 1: synchronous clear of `tag_error` and `trunc_error`.

## Operation

- Reset value of every output and internal register is 0. The state machine resets to IDLE. The tag-checker is unarmed after reset.
- **IDLE**
  - If `enable && !roc_empty && !ew_full`: assert `roc_re`, go to HDR.
- **HDR** (header word valid on `roc_data`)
  - Write the header unchanged to the EW_FIFO: `ew_we`=1, `ew_data`=`roc_data`.
  - Latch size=`roc_data[31:20]` and tag=`roc_data[19:0]`. Clear the forwarded-word counter and the stall counter.
  - Tag check: if armed and tag != expected, set `tag_error`. Always set expected = tag+1 (mod 2^20) and arm.
  - If size==0, go to DONE; else go to PAYLOAD.
- **PAYLOAD**
  - Read issue: assert `roc_re` when issued < size, `!roc_empty` and `!ew_full`.
  - Write: every read is written to the EW_FIFO exactly one cycle later (`ew_we`=1, `ew_data`=`roc_data`), unconditionally. Each write increments the forwarded count.
  - Stall counter: increments on every PAYLOAD cycle without `roc_re` while issued < size, and resets to 0 on each `roc_re`.
  - When the stall counter reaches `TIMEOUT_CYC`, set `trunc_error` and go to DONE.
  - When issued == size and the last write has occurred, go to DONE.
  - Maximum throughput is one word per cycle.
- **DONE**
  - Pulse `ew_done`.
  - `ew_size` ← forwarded count; `ew_tag` ← latched tag; `evt_cnt` ← `evt_cnt`+1.
  - Go to IDLE.
- Truncated events: leftover ROC words are not flushed. The next word read is parsed as a header, and resync is handled by software.
- `enable` deasserted mid-event: the event completes normally; no new event starts.
- `clear_err` with a simultaneous error set: the set wins.
- Arithmetic widths:
  - issued and forwarded counters: 12 bits. The maximum is 4095, so they never wrap.
  - stall counter: wide enough for `TIMEOUT_CYC`.
- Reset mid-event: all state is dropped immediately; no `ew_done` is produced.

## Timing

- Header latency: `roc_re` (IDLE) in cycle N → header `ew_we` in N+1.
- Payload latency: first payload `roc_re` no earlier than N+2.
- Read-to-write: each payload `roc_re` in cycle M → `ew_we` in M+1.
- `ew_done`: asserted the cycle after the last payload write, or the cycle after HDR when size==0.
- Back-to-back events: the next header `roc_re` comes no earlier than the cycle after `ew_done`.
- Backpressure: `ew_full` is sampled in the cycle `roc_re` would be issued. One write can land after `ew_full` rises, which is why one slot of margin is required.
- `ew_size`, `ew_tag` and `evt_cnt` update in the same cycle as the `ew_done` pulse and hold until the next `ew_done`.

## Test plan

- **Nominal event:** header 0x01000005 (size 16, tag 5) + payload 0x0..0xF, `ew_full`=0 → 17 EW writes in order, one `ew_done`, `ew_size`=16, `ew_tag`=5, `evt_cnt`=1, no errors.
- **Empty event:** header 0x00000006 (size 0, tag 6) → single EW write 0x00000006 and `ew_done` in the next cycle with `ew_size`=0.
- **Tag continuity:**
  - Tags 5, 9, 10 → `tag_error` rises during the header cycle of tag 9; tag 10 adds no new error.
  - `clear_err` pulse → `tag_error`=0.
  - Tag wrap 0xFFFFF→0x00000 → no error.
- **Backpressure:** size 0xFFF, `ew_full` toggling each cycle and `roc_empty` random → all 4096 words written exactly once, in order, with no `roc_re` in any cycle with `ew_full`=1.
- **Timeout:** `TIMEOUT_CYC`=16, header size 8 with only 3 payload words, then `roc_empty`=1 → after 16 stall cycles: `trunc_error`=1, `ew_done` with `ew_size`=3, state IDLE.
- **Reset mid-payload:** assert `serdesclk_resetn`=0 mid-payload → all outputs 0 asynchronously. After release with `enable`=0 → `roc_re` stays 0 regardless of `roc_empty`.
